// File: rtl/if_id_stage.sv
// if_id_stage
//
// IF/ID pipeline register for the 5-stage MIPS pipeline. It has built-in load-use hazard
// detection and branch flush, and sits directly upstream of the ID/EX register.
//
// Behaviour:
//   - Latches the fetched instruction and PC+4.
//   - Decodes rs/rt/rd and the sign-extended immediate for the ID/EX inputs.
//   - Freezes fetch for one cycle on a load-use hazard.
//   - Squashes wrong-path instructions when EX resolves a taken branch.
//
// Ports:
//   clock          in   1   pipeline clock, rising edge
//   reset          in   1   synchronous, active-high
//   pc4            in  32   PC+4 from fetch
//   instr          in  32   fetched instruction
//   idex_mem_read  in   1   MemRead of the instruction in ID/EX
//   idex_rt        in   5   Rt of the instruction in ID/EX
//   branch_taken   in   1   branch resolved taken in EX this cycle
//   pc4_out        out 32   registered PC+4
//   instr_out      out 32   registered instruction (0 = NOP)
//   rs_out         out  5   instr_out[25:21]
//   rt_out         out  5   instr_out[20:16]
//   rd_out         out  5   instr_out[15:11]
//   imm_out        out 32   sign-extended instr_out[15:0]
//   valid_out      out  1   register holds a live instruction
//   pc_write       out  1   PC enable; 0 freezes fetch
//   bubble         out  1   ID must inject all-zero controls into ID/EX
//   stall_cnt      out 16   saturating stall count   (HAZARD_CNT_EN only)
//   flush_cnt      out 16   saturating flush count   (HAZARD_CNT_EN only)
//
// Build option: define HAZARD_CNT_EN to add the stall/flush event counters.

module if_id_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc4,
  input  logic [31:0] instr,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rt,
  input  logic        branch_taken,
  output logic [31:0] pc4_out,
  output logic [31:0] instr_out,
  output logic [4:0]  rs_out,
  output logic [4:0]  rt_out,
  output logic [4:0]  rd_out,
  output logic [31:0] imm_out,
  output logic        valid_out,
  output logic        pc_write,
  output logic        bubble
`ifdef HAZARD_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  // Opcodes relevant to source-register usage.
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpSw    = 6'h2B;

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic [5:0]  opcode;
  logic        use_rs;
  logic        use_rt;
  logic        hazard;
  logic        stall;

  // Field decode from the registered instruction.
  assign opcode    = instr_q[31:26];
  assign rs_out    = instr_q[25:21];
  assign rt_out    = instr_q[20:16];
  assign rd_out    = instr_q[15:11];
  assign imm_out   = {{16{instr_q[15]}}, instr_q[15:0]};
  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;

  // j/jal read no registers. Only R-type, branches and stores read rt as a source.
  always_comb begin
    use_rs = valid_q && (opcode != OpJ) && (opcode != OpJal);
    use_rt = valid_q && ((opcode == OpRtype) || (opcode == OpBeq) ||
                         (opcode == OpBne)   || (opcode == OpSw));
  end

  // $0 is hardwired, so a load targeting it can never feed a dependent instruction.
  always_comb begin
    hazard = idex_mem_read && (idex_rt != 5'd0) &&
             ((use_rs && (rs_out == idex_rt)) || (use_rt && (rt_out == idex_rt)));
  end

  // A taken branch flushes the stalled instruction anyway, so it overrides the stall.
  assign stall    = hazard && !branch_taken;
  assign pc_write = !stall;
  assign bubble   = branch_taken || hazard || !valid_q;

  // Next-state logic. Priority is branch flush > hazard hold > normal load.
  // Reset is applied in the register block.
  always_comb begin
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    state_d = state_q;

    if (branch_taken) begin
      pc4_d   = 32'd0;
      instr_d = 32'd0;
      valid_d = 1'b0;
      state_d = StRun;
    end else if (hazard) begin
      // Hold every field. The bubble sent into ID/EX clears idex_mem_read next cycle,
      // so STALL lasts exactly one cycle.
      state_d = StStall;
    end else begin
      pc4_d   = pc4;
      instr_d = instr;
      valid_d = (instr != 32'd0);
      state_d = StRun;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc4_q   <= 32'd0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      state_q <= StRun;
    end else begin
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

`ifdef HAZARD_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (branch_taken && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage.
// Inputs change 1 time unit after the rising clock edge. Outputs are checked there too.

module tb_if_id_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        idex_mem_read;
  logic [4:0]  idex_rt;
  logic        branch_taken;
  logic [31:0] pc4_out;
  logic [31:0] instr_out;
  logic [4:0]  rs_out;
  logic [4:0]  rt_out;
  logic [4:0]  rd_out;
  logic [31:0] imm_out;
  logic        valid_out;
  logic        pc_write;
  logic        bubble;
`ifdef HAZARD_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  if_id_stage u_dut (
    .clock         (clock),
    .reset         (reset),
    .pc4           (pc4),
    .instr         (instr),
    .idex_mem_read (idex_mem_read),
    .idex_rt       (idex_rt),
    .branch_taken  (branch_taken),
    .pc4_out       (pc4_out),
    .instr_out     (instr_out),
    .rs_out        (rs_out),
    .rt_out        (rt_out),
    .rd_out        (rd_out),
    .imm_out       (imm_out),
    .valid_out     (valid_out),
    .pc_write      (pc_write),
    .bubble        (bubble)
`ifdef HAZARD_CNT_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Load one instruction into IF/ID with no hazard or branch active.
  task automatic load(input logic [31:0] i, input logic [31:0] p);
    idex_mem_read = 1'b0;
    idex_rt       = 5'd0;
    branch_taken  = 1'b0;
    instr         = i;
    pc4           = p;
    step();
  endtask

  initial begin
    reset         = 1'b1;
    pc4           = 32'h0;
    instr         = 32'h0;
    idex_mem_read = 1'b0;
    idex_rt       = 5'd0;
    branch_taken  = 1'b0;
    step();
    step();
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc4", pc4_out, 32'h0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_pc_write", {31'd0, pc_write}, 32'd1);
    check("rst_bubble", {31'd0, bubble}, 32'd1);
`ifdef HAZARD_CNT_EN
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
`endif
    reset = 1'b0;

    // Straight-line: add $10,$8,$9.
    load(32'h0109_5020, 32'h4);
    check("add_rs", {27'd0, rs_out}, 32'd8);
    check("add_rt", {27'd0, rt_out}, 32'd9);
    check("add_rd", {27'd0, rd_out}, 32'd10);
    check("add_imm", imm_out, 32'h0000_5020);
    check("add_pc4", pc4_out, 32'h4);
    check("add_valid", {31'd0, valid_out}, 32'd1);
    check("add_bubble", {31'd0, bubble}, 32'd0);

    // Load-use on rt: the register must hold while the next fetch waits.
    instr         = 32'h1111_1111;
    pc4           = 32'h8;
    idex_mem_read = 1'b1;
    idex_rt       = 5'd9;
    #1;
    check("lu_pc_write", {31'd0, pc_write}, 32'd0);
    check("lu_bubble", {31'd0, bubble}, 32'd1);
    step();
    check("lu_hold_instr", instr_out, 32'h0109_5020);
    check("lu_hold_pc4", pc4_out, 32'h4);
    idex_mem_read = 1'b0;
    #1;
    check("lu_release_pc_write", {31'd0, pc_write}, 32'd1);
    check("lu_release_bubble", {31'd0, bubble}, 32'd0);
`ifdef HAZARD_CNT_EN
    check("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
`endif
    // Load-use on rs.
    idex_mem_read = 1'b1;
    idex_rt       = 5'd8;
    #1;
    check("lu_rs_pc_write", {31'd0, pc_write}, 32'd0);
    idex_mem_read = 1'b0;

    // lw $9,-4($8): rt is the destination, so no stall on rt. A stall on rs is still required.
    load(32'h8D09_FFFC, 32'hC);
    check("lw_imm", imm_out, 32'hFFFF_FFFC);
    idex_mem_read = 1'b1;
    idex_rt       = 5'd9;
    #1;
    check("lw_rt_no_stall", {31'd0, pc_write}, 32'd1);
    check("lw_rt_no_bubble", {31'd0, bubble}, 32'd0);
    idex_rt = 5'd8;
    #1;
    check("lw_rs_stall", {31'd0, pc_write}, 32'd0);

    // addi $9,$0,5 with a load to $0: never a hazard.
    load(32'h2009_0005, 32'h10);
    idex_mem_read = 1'b1;
    idex_rt       = 5'd0;
    #1;
    check("r0_no_stall", {31'd0, pc_write}, 32'd1);

    // A jump whose rs field bits equal idex_rt must not stall.
    load(32'h0900_0000, 32'h14);
    idex_mem_read = 1'b1;
    idex_rt       = 5'd8;
    #1;
    check("j_no_stall", {31'd0, pc_write}, 32'd1);

    // Flush of a valid add.
    load(32'h0109_5020, 32'h20);
    branch_taken = 1'b1;
    instr        = 32'h2222_2222;
    pc4          = 32'h24;
    #1;
    check("fl_bubble", {31'd0, bubble}, 32'd1);
    check("fl_pc_write", {31'd0, pc_write}, 32'd1);
    step();
    branch_taken = 1'b0;
    check("fl_instr", instr_out, 32'h0);
    check("fl_valid", {31'd0, valid_out}, 32'd0);
    check("fl_pc4", pc4_out, 32'h0);
`ifdef HAZARD_CNT_EN
    check("fl_flush_cnt", {16'd0, flush_cnt}, 32'd1);
`endif

    // Branch and hazard together: the flush wins.
    load(32'h0109_5020, 32'h28);
    idex_mem_read = 1'b1;
    idex_rt       = 5'd9;
    branch_taken  = 1'b1;
    #1;
    check("bh_pc_write", {31'd0, pc_write}, 32'd1);
    check("bh_bubble", {31'd0, bubble}, 32'd1);
    step();
    branch_taken = 1'b0;
    check("bh_instr", instr_out, 32'h0);
    check("bh_valid", {31'd0, valid_out}, 32'd0);
`ifdef HAZARD_CNT_EN
    check("bh_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    check("bh_flush_cnt", {16'd0, flush_cnt}, 32'd2);
`endif

    // Reset during a stall.
    load(32'h0109_5020, 32'h30);
    idex_mem_read = 1'b1;
    idex_rt       = 5'd9;
    #1;
    check("rs_pre_stall", {31'd0, pc_write}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rs_instr", instr_out, 32'h0);
    check("rs_valid", {31'd0, valid_out}, 32'd0);
    check("rs_pc_write", {31'd0, pc_write}, 32'd1);

    // A fetched all-zero word is a NOP and is not live.
    load(32'h0000_0000, 32'h34);
    check("nop_valid", {31'd0, valid_out}, 32'd0);
    check("nop_bubble", {31'd0, bubble}, 32'd1);

`ifdef HAZARD_CNT_EN
    check("sat_start_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    branch_taken = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      step();
    end
    check("sat_flush_cnt", {16'd0, flush_cnt}, 32'h0000_FFFF);
    step();
    check("sat_flush_hold", {16'd0, flush_cnt}, 32'h0000_FFFF);
    branch_taken = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
